// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch: four-digit BCD stopwatch (SS.hh, 00.00 .. 59.99).
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   btn_start_n  raw start/stop push button (active-low, async to clk)
//   btn_clear_n  raw clear push button (active-low, async to clk)
//   digits       [15:12] sec tens, [11:8] sec units, [7:4] tenths, [3:0] hundredths
//   running      high while counting
//   ovf          sticky, set on the 59.99 -> 00.00 wrap, cleared by a clear press

// Per-button conditioning: 2-flop synchroniser, debounce, falling-edge press pulse.
//   i_btn_n  raw active-low button
//   o_press  one-cycle pulse on a debounced press (release gives nothing)
module bcd_stopwatch_btn #(
  parameter int DEB_CYC = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn_n,
  output logic o_press
);
  localparam int CW = $clog2(DEB_CYC + 1);

  logic          r_sync1, r_sync2, r_deb, r_deb_d;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_deb   <= 1'b1;
      r_deb_d <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      // Any return to the debounced level restarts the qualification window.
      if (r_sync2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEB_CYC - 1)) begin
        r_deb <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_deb_d & ~r_deb;
endmodule

module bcd_stopwatch #(
  parameter int DIV     = 500000,
  parameter int DEB_CYC = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_start_n,
  input  logic        btn_clear_n,
  output logic [15:0] digits,
  output logic        running,
  output logic        ovf
);
  localparam int PW = $clog2(DIV);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2} state_t;

  state_t        r_state, w_next;
  logic          r_running, r_ovf;
  logic [PW-1:0] r_presc;
  logic [15:0]   r_digits, w_inc;
  logic [1:0]    w_btn_n, w_press;
  logic          w_start, w_clear, w_clr, w_tick;

  assign w_btn_n = {btn_clear_n, btn_start_n};

  for (genvar g = 0; g < 2; g++) begin : g_btn
    bcd_stopwatch_btn #(.DEB_CYC(DEB_CYC)) u_btn (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_btn_n (w_btn_n[g]),
      .o_press (w_press[g])
    );
  end

  assign w_start = w_press[0];
  assign w_clear = w_press[1];

  // Clear only acts outside RUN; when both press together, that rule alone
  // gives start priority in RUN and clear priority elsewhere.
  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_clear)      w_clr  = 1'b1;
        else if (w_start) w_next = S_RUN;
      end
      S_RUN: begin
        if (w_start) w_next = S_PAUSE;
      end
      S_PAUSE: begin
        if (w_clear) begin
          w_clr  = 1'b1;
          w_next = S_IDLE;
        end else if (w_start) begin
          w_next = S_RUN;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_tick = (r_state == S_RUN) && (r_presc == PW'(DIV - 1));

  // BCD ripple increment; >= keeps any nibble from ever leaving 0..9.
  always_comb begin
    w_inc = r_digits;
    if (r_digits[3:0] >= 4'd9) begin
      w_inc[3:0] = 4'd0;
      if (r_digits[7:4] >= 4'd9) begin
        w_inc[7:4] = 4'd0;
        if (r_digits[11:8] >= 4'd9) begin
          w_inc[11:8] = 4'd0;
          if (r_digits[15:12] >= 4'd5) w_inc[15:12] = 4'd0;
          else                         w_inc[15:12] = r_digits[15:12] + 4'd1;
        end else begin
          w_inc[11:8] = r_digits[11:8] + 4'd1;
        end
      end else begin
        w_inc[7:4] = r_digits[7:4] + 4'd1;
      end
    end else begin
      w_inc[3:0] = r_digits[3:0] + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_running <= 1'b0;
      r_presc   <= '0;
      r_digits  <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_running <= (w_next == S_RUN);
      if (w_clr) begin
        r_presc  <= '0;
        r_digits <= '0;
        r_ovf    <= 1'b0;
      end else if (r_state == S_RUN) begin
        // Prescaler is untouched outside RUN so a pause keeps the partial tick.
        if (w_tick) begin
          r_presc  <= '0;
          r_digits <= w_inc;
          if (r_digits == 16'h5999) r_ovf <= 1'b1;
        end else begin
          r_presc <= r_presc + 1'b1;
        end
      end
    end
  end

  assign digits  = r_digits;
  assign running = r_running;
  assign ovf     = r_ovf;
endmodule

// File: tb/tb_bcd_stopwatch.sv
module tb_bcd_stopwatch;
  localparam int DIV = 4;
  localparam int DEB = 3;
  localparam int LAT = DEB + 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bs = 1'b1;
  logic        bc = 1'b1;
  logic [15:0] digits;
  logic        running, ovf;

  int n_vec = 0;
  int n_err = 0;

  // Reference: hundredths count, edges since last tick, state (0 idle/1 run/2 pause).
  int cnt = 0;
  int phase = 0;
  int st = 0;

  bcd_stopwatch #(.DIV(DIV), .DEB_CYC(DEB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_start_n (bs),
    .btn_clear_n (bc),
    .digits      (digits),
    .running     (running),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] bcd(input int c);
    return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  // Advance one edge, update the reference with any press event the DUT sees
  // on this edge, and leave time 1 unit after the edge.
  task automatic step(input bit es, input bit ec);
    @(posedge clk);
    if (st == 1) begin
      phase++;
      if (phase == DIV) begin
        phase = 0;
        cnt++;
        if (cnt == 6000) cnt = 0;
      end
      if (es) st = 2;
    end else if (ec) begin
      st = 0; cnt = 0; phase = 0;
    end else if (es) begin
      st = 1;
    end
    #1;
  endtask

  task automatic press(input bit s, input bit c, input int hold, input int rel);
    bs = ~s;
    bc = ~c;
    for (int k = 1; k <= hold; k++) step(s && k == LAT, c && k == LAT);
    bs = 1'b1;
    bc = 1'b1;
    repeat (rel) step(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    #12;
    n_vec++; if (digits !== 16'h0000) begin n_err++; $display("FAIL reset_digits: got %h want 0000", digits); end
    n_vec++; if (running !== 1'b0) begin n_err++; $display("FAIL reset_running: got %b want 0", running); end
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) step(1'b0, 1'b0);
    n_vec++; if (running !== 1'b0 || digits !== 16'h0000) begin
      n_err++; $display("FAIL reset_idle: got run=%b dig=%h want 0/0000", running, digits); end
  endtask

  task automatic test_start();
    logic [15:0] exp_d;
    bs = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step(k == LAT, 1'b0);
      exp_d = (k >= 10) ? 16'h0001 : 16'h0000;
      n_vec++; if (running !== (k >= LAT)) begin
        n_err++; $display("FAIL start_running_k%0d: got %b want %b", k, running, (k >= LAT)); end
      n_vec++; if (digits !== exp_d) begin
        n_err++; $display("FAIL start_digits_k%0d: got %h want %h", k, digits, exp_d); end
    end
    bs = 1'b1;
    repeat (8) step(1'b0, 1'b0);
    n_vec++; if (digits !== 16'h0003 || running !== 1'b1) begin
      n_err++; $display("FAIL start_period: got dig=%h run=%b want 0003/1", digits, running); end
  endtask

  task automatic test_glitch();
    bs = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    bs = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 1'b0);
      n_vec++; if (running !== 1'b1 || digits !== bcd(cnt)) begin
        n_err++; $display("FAIL glitch_k%0d: got run=%b dig=%h want 1/%h", k, running, digits, bcd(cnt)); end
    end
  endtask

  task automatic test_clear_in_run();
    int c0;
    c0 = cnt;
    press(1'b0, 1'b1, 10, 8);
    n_vec++; if (running !== 1'b1 || digits !== bcd(cnt) || cnt == c0) begin
      n_err++; $display("FAIL clear_in_run: got run=%b dig=%h want 1/%h", running, digits, bcd(cnt)); end
  endtask

  task automatic test_carry();
    int g;
    for (g = 0; g < 6000 && cnt != 1000; g++) begin
      step(1'b0, 1'b0);
      n_vec++; if (digits !== bcd(cnt)) begin
        n_err++; $display("FAIL carry_digits: got %h want %h", digits, bcd(cnt)); end
      for (int i = 0; i < 4; i++)
        if (digits[i*4 +: 4] > 4'd9) begin
          n_err++; $display("FAIL carry_nibble%0d: got %h want <=9", i, digits[i*4 +: 4]); end
      if (phase == 0 && (cnt == 10 || cnt == 100 || cnt == 1000)) begin
        n_vec++;
        if ((cnt == 10 && digits !== 16'h0010) || (cnt == 100 && digits !== 16'h0100) ||
            (cnt == 1000 && digits !== 16'h1000)) begin
          n_err++; $display("FAIL carry_boundary_%0d: got %h", cnt, digits); end
      end
    end
    n_vec++; if (cnt != 1000) begin n_err++; $display("FAIL carry_timeout: got cnt %0d want 1000", cnt); end
  endtask

  task automatic test_pause_resume();
    int fz;
    for (int g = 0; g < 8 && phase != 0; g++) step(1'b0, 1'b0);
    // Press started right after a tick: the pause lands with prescaler at 2.
    bs = 1'b0;
    for (int k = 1; k <= 8; k++) step(k == LAT, 1'b0);
    bs = 1'b1;
    fz = cnt;
    n_vec++; if (running !== 1'b0) begin n_err++; $display("FAIL pause_running: got %b want 0", running); end
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b0);
      n_vec++; if (digits !== bcd(fz)) begin
        n_err++; $display("FAIL pause_frozen_k%0d: got %h want %h", k, digits, bcd(fz)); end
    end
    bs = 1'b0;
    for (int k = 1; k <= LAT; k++) step(k == LAT, 1'b0);
    n_vec++; if (running !== 1'b1 || digits !== bcd(fz)) begin
      n_err++; $display("FAIL resume_state: got run=%b dig=%h want 1/%h", running, digits, bcd(fz)); end
    step(1'b0, 1'b0);
    n_vec++; if (digits !== bcd(fz)) begin
      n_err++; $display("FAIL resume_edge1: got %h want %h", digits, bcd(fz)); end
    step(1'b0, 1'b0);
    n_vec++; if (digits !== bcd(fz + 1)) begin
      n_err++; $display("FAIL resume_edge2: got %h want %h", digits, bcd(fz + 1)); end
    bs = 1'b1;
    repeat (8) step(1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    for (int g = 0; g < 30000 && cnt != 5999; g++) begin
      step(1'b0, 1'b0);
      n_vec++; if (digits !== bcd(cnt)) begin
        n_err++; $display("FAIL wrap_run_digits: got %h want %h", digits, bcd(cnt)); end
    end
    n_vec++; if (digits !== 16'h5999 || ovf !== 1'b0) begin
      n_err++; $display("FAIL wrap_pre: got dig=%h ovf=%b want 5999/0", digits, ovf); end
    for (int g = 0; g < 8 && cnt != 0; g++) step(1'b0, 1'b0);
    n_vec++; if (digits !== 16'h0000 || ovf !== 1'b1 || running !== 1'b1) begin
      n_err++; $display("FAIL wrap_edge: got dig=%h ovf=%b run=%b want 0000/1/1", digits, ovf, running); end
    repeat (DIV) step(1'b0, 1'b0);
    n_vec++; if (digits !== 16'h0001 || ovf !== 1'b1) begin
      n_err++; $display("FAIL wrap_continue: got dig=%h ovf=%b want 0001/1", digits, ovf); end
    press(1'b1, 1'b0, 8, 8);
    n_vec++; if (running !== 1'b0 || ovf !== 1'b1) begin
      n_err++; $display("FAIL wrap_pause: got run=%b ovf=%b want 0/1", running, ovf); end
    press(1'b0, 1'b1, 8, 8);
    n_vec++; if (digits !== 16'h0000 || ovf !== 1'b0 || running !== 1'b0) begin
      n_err++; $display("FAIL wrap_clear: got dig=%h ovf=%b run=%b want 0000/0/0", digits, ovf, running); end
  endtask

  task automatic test_simul();
    press(1'b1, 1'b0, 8, 8);
    repeat (10) step(1'b0, 1'b0);
    press(1'b1, 1'b0, 8, 8);
    n_vec++; if (running !== 1'b0 || digits !== bcd(cnt) || cnt == 0) begin
      n_err++; $display("FAIL simul_pause: got run=%b dig=%h want 0/%h", running, digits, bcd(cnt)); end
    press(1'b1, 1'b1, 8, 8);
    n_vec++; if (running !== 1'b0 || digits !== 16'h0000) begin
      n_err++; $display("FAIL simul_clear: got run=%b dig=%h want 0/0000", running, digits); end
    repeat (8) step(1'b0, 1'b0);
    n_vec++; if (running !== 1'b0 || digits !== 16'h0000) begin
      n_err++; $display("FAIL simul_idle: got run=%b dig=%h want 0/0000", running, digits); end
  endtask

  task automatic test_async_reset();
    press(1'b1, 1'b0, 8, 8);
    for (int g = 0; g < 8000 && cnt != 1234; g++) step(1'b0, 1'b0);
    n_vec++; if (digits !== 16'h1234 || running !== 1'b1) begin
      n_err++; $display("FAIL areset_pre: got dig=%h run=%b want 1234/1", digits, running); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (digits !== 16'h0000 || running !== 1'b0 || ovf !== 1'b0) begin
      n_err++; $display("FAIL areset_now: got dig=%h run=%b ovf=%b want 0000/0/0", digits, running, ovf); end
    st = 0; cnt = 0; phase = 0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    repeat (10) step(1'b0, 1'b0);
    n_vec++; if (digits !== 16'h0000 || running !== 1'b0) begin
      n_err++; $display("FAIL areset_idle: got dig=%h run=%b want 0000/0", digits, running); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_glitch();
    test_clear_in_run();
    test_carry();
    test_pause_resume();
    test_wrap();
    test_simul();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bcd_stopwatch.md
Name: bcd_stopwatch

Overview:
- Four-digit BCD stopwatch counter (SS.hh, 00.00 to 59.99) for the DE0 board.
- Sits directly upstream of the per-digit seven-segment decoders. Each 4-bit nibble of `digits` feeds one decoder instance, so every nibble must stay in the range 0-9.
- Takes two raw active-low push buttons (start/stop, clear) and does its own synchronisation, debounce and press detection.

Parameters:
- DIV, 500000, clk cycles per 0.01 s tick (50 MHz / 100 Hz); must be >= 2.
- DEB_CYC, 500000, consecutive clk cycles a synchronised button level must differ from its debounced level before the debounced level updates (10 ms); must be >= 1.

Ports:
- clk  in  1  system clock, single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- btn_start_n  in  1  raw start/stop button, active-low, asynchronous to clk.
- btn_clear_n  in  1  raw clear button, active-low, asynchronous to clk.
- digits  out  16  BCD digits: [15:12] seconds tens (0-5), [11:8] seconds units, [7:4] tenths, [3:0] hundredths.
- running  out  1  high while in RUN.
- ovf  out  1  sticky flag, set on wrap 59.99 -> 00.00.

Behaviour:
- Reset: one clock, one reset.
  - Reset is asynchronous, active-low, on `rst_n`.
  - Reset values: all registers clear; digits=16'h0000, running=0, ovf=0, FSM=IDLE, prescaler=0.
  - Synchroniser and debounced levels reset to 1 (released).
  - Reset asserted mid-count returns everything to these values immediately, without waiting for a clock edge.
- Input conditioning, per button:
  - 2-flop synchroniser.
  - Debounce counter: increments while sync != debounced, clears when they are equal. When it reaches DEB_CYC-1 with a mismatch, debounced <= sync and the counter clears.
  - Press event = 1-cycle pulse on a debounced 1->0 transition. Releases generate no event.
  - Glitches shorter than DEB_CYC cycles produce no event.
- Latency: a clean press held low produces its state change on the (DEB_CYC+3)th rising edge after the first rising edge that samples the low level.
- FSM states and transitions:
  - IDLE, start press -> RUN.
  - RUN, start press -> PAUSE.
  - PAUSE, start press -> RUN.
  - IDLE or PAUSE, clear press -> IDLE: digits=0, ovf=0, prescaler=0.
  - RUN, clear press -> ignored.
  - Start and clear press in the same cycle: in RUN, start wins (-> PAUSE, clear dropped); in IDLE or PAUSE, clear wins.
  - running = (state == RUN), registered.
- Prescaler:
  - Counts 0..DIV-1 only in RUN.
  - Held, not cleared, in PAUSE, so the fractional tick resumes where it stopped.
  - When it equals DIV-1 in RUN: prescaler <= 0 and the BCD count increments on the same edge. Digits are registered and change exactly on that edge.
- BCD increment:
  - Hundredths 9 -> 0 carries to tenths; tenths 9 -> 0 carries to seconds units; units 9 -> 0 carries to tens.
  - Tens 5 with carry -> 0.
  - 59.99 + tick -> 00.00, ovf <= 1 on the same edge; counting continues.
  - No nibble may ever hold 10-15.
- Tick and start press on the same edge in RUN: the increment is applied and the state goes to PAUSE.

Test Plan (DIV=4, DEB_CYC=3 unless noted):
- Reset while RUN at 12.34 -> digits=16'h0000, running=0, ovf=0 asynchronously; after release, state IDLE.
- Start press held 10 cycles from IDLE -> running=1 on the 6th edge. Digits then read 00.01 after 4 more edges and increment every 4 clk cycles.
- Run through 00.09 -> 00.10, 00.99 -> 01.00, 09.99 -> 10.00; every nibble is always <= 9.
- Preload near wrap, or DIV=2 with long run: 59.99 tick -> digits=16'h0000, ovf=1, running stays 1. Then pause and clear -> ovf=0, digits=0.
- Pause mid-tick with prescaler=2, hold 20 cycles -> digits frozen. Resume -> next increment after 2 RUN cycles (prescaler 2->3->tick), not 4.
- Glitches:
  - 2-cycle low glitch on btn_start_n -> no state change.
  - Clear press during RUN -> ignored, counting continues.
  - Simultaneous start+clear in PAUSE -> IDLE with digits=0.
